// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART receive front end.
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Decision that is waiting for its centre+1 sample (majority-vote build).
    typedef enum logic [1:0] {PEND_NONE, PEND_START, PEND_DATA, PEND_STOP} pend_t;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; flops reset to idle (high).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX front end: start-bit qualification, data-bit centre sampling, stop-bit check.
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around every bit centre.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_tick,
    input  logic rx_in,
    output logic sample_en,
    output logic serial_out,
    output logic busy,
    output logic frame_done,
    output logic frame_err
);

    localparam int unsigned OS_W = cnt_width(OVERSAMPLE);
    localparam int unsigned BC_W = cnt_width(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic            w_rx;
    state_t          r_state,     w_state;
    logic            r_armed,     w_armed;
    logic [OS_W-1:0] r_os_cnt,    w_os_cnt;
    logic [BC_W-1:0] r_bit_cnt,   w_bit_cnt;
    logic            r_sample_en, w_sample_en;
    logic            r_serial,    w_serial;
    logic            r_busy,      w_busy;
    logic            r_done,      w_done;
    logic            r_err,       w_err;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]      r_hist,      w_hist;
    pend_t           r_pend,      w_pend;
    logic            w_maj;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_async(rx_in),
        .o_sync (w_rx)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // r_hist holds rx from the two previous ticks: centre-1 and centre at a centre+1 tick.
    assign w_maj = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`endif

    always_comb begin
        w_state     = r_state;
        w_armed     = r_armed;
        w_os_cnt    = r_os_cnt;
        w_bit_cnt   = r_bit_cnt;
        w_sample_en = 1'b0;
        w_serial    = r_serial;
        w_done      = 1'b0;
        w_err       = 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
        w_hist      = r_hist;
        w_pend      = r_pend;
`endif
        if (baud_tick) begin
`ifdef UART_RX_MAJORITY_VOTE_EN
            w_hist = {r_hist[0], w_rx};
            w_pend = PEND_NONE;
`endif
            unique case (r_state)
                IDLE: begin
                    if (r_armed && !w_rx) begin
                        w_state  = START;
                        w_os_cnt = '0;
                        w_armed  = 1'b0;
                    end else if (w_rx) begin
                        w_armed = 1'b1;
                    end
                end
                START: begin
                    if (r_os_cnt == OS_MID) begin
                        w_os_cnt = '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
                        w_state   = DATA;
                        w_bit_cnt = '0;
                        w_pend    = PEND_START;
`else
                        if (!w_rx) begin
                            w_state   = DATA;
                            w_bit_cnt = '0;
                        end else begin
                            w_state = IDLE;
                            w_armed = 1'b1;
                        end
`endif
                    end else begin
                        w_os_cnt = r_os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_os_cnt == OS_LAST) begin
                        w_os_cnt  = '0;
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BC_LAST) begin
                            w_state = STOP;
                        end
`ifdef UART_RX_MAJORITY_VOTE_EN
                        w_pend = PEND_DATA;
`else
                        w_sample_en = 1'b1;
                        w_serial    = w_rx;
`endif
                    end else begin
                        w_os_cnt = r_os_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_os_cnt == OS_LAST) begin
                        w_os_cnt = '0;
`ifdef UART_RX_MAJORITY_VOTE_EN
                        w_pend = PEND_STOP;
`else
                        w_state = IDLE;
                        w_armed = w_rx;
                        w_done  = w_rx;
                        w_err   = !w_rx;
`endif
                    end else begin
                        w_os_cnt = r_os_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef UART_RX_MAJORITY_VOTE_EN
            // Counting above runs on the centre wrap as usual; the vote resolves one tick later.
            unique case (r_pend)
                PEND_START: begin
                    if (w_maj) begin
                        w_state  = IDLE;
                        w_os_cnt = '0;
                        w_armed  = 1'b1;
                        w_err    = 1'b1;
                    end
                end
                PEND_DATA: begin
                    w_sample_en = 1'b1;
                    w_serial    = w_maj;
                end
                PEND_STOP: begin
                    w_state  = IDLE;
                    w_os_cnt = '0;
                    w_armed  = w_maj;
                    w_done   = w_maj;
                    w_err    = !w_maj;
                end
                default: ;
            endcase
`endif
        end
        // Busy covers the final pulse cycle, dropping the cycle after it.
        w_busy = (w_state != IDLE) || w_done || w_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_sample_en <= 1'b0;
            r_serial    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            r_hist      <= '1;
            r_pend      <= PEND_NONE;
`endif
        end else begin
            r_state     <= w_state;
            r_armed     <= w_armed;
            r_os_cnt    <= w_os_cnt;
            r_bit_cnt   <= w_bit_cnt;
            r_sample_en <= w_sample_en;
            r_serial    <= w_serial;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
`ifdef UART_RX_MAJORITY_VOTE_EN
            r_hist      <= w_hist;
            r_pend      <= w_pend;
`endif
        end
    end

    assign sample_en  = r_sample_en;
    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed self-checking bench for uart_rx_sampler (default and majority-vote builds).
module tb_uart_rx_sampler;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic baud_tick;
    logic rx_in;
    logic sample_en;
    logic serial_out;
    logic busy;
    logic frame_done;
    logic frame_err;

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .sample_en (sample_en),
        .serial_out(serial_out),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_div = 4;
    int frame_c0 = 0;

    // Output monitor: counts pulses, captures sampled bits and busy episodes.
    int          mcyc = 0;
    int          n_samp = 0, n_done = 0, n_err = 0, n_bad = 0;
    int          busy_rises = 0, busy_run = 0, last_run = 0, last_pulse = 0, busy_fall = 0;
    logic [15:0] shreg = '1;
    int          samp_q[$];
    logic        prev_se = 1'b0, prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

    initial forever begin
        @(negedge clk);
        mcyc++;
        if (int'(sample_en) + int'(frame_done) + int'(frame_err) > 1) n_bad++;
        if ((sample_en && prev_se) || (frame_done && prev_done) || (frame_err && prev_err)) n_bad++;
        if (sample_en) begin
            n_samp++;
            shreg = {serial_out, shreg[15:1]};
            samp_q.push_back(mcyc);
        end
        if (frame_done) begin n_done++; last_pulse = mcyc; end
        if (frame_err)  begin n_err++;  last_pulse = mcyc; end
        if (busy) begin
            if (!prev_busy) busy_rises++;
            busy_run++;
        end else if (prev_busy) begin
            last_run  = busy_run;
            busy_run  = 0;
            busy_fall = mcyc;
        end
        prev_se   = sample_en;
        prev_done = frame_done;
        prev_err  = frame_err;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            baud_tick = ((cyc % tick_div) == 0);
        end
    endtask

    task automatic idle(input int nticks);
        rx_in = 1'b1;
        step(nticks * tick_div);
    endtask

    task automatic align();
        while (((cyc + 1) % tick_div) != 0) step();
        frame_c0 = cyc + 1;
    endtask

    task automatic drive_bit(input logic b, input int inv_lo, input int inv_hi);
        for (int k = 0; k < 16 * tick_div; k++) begin
            step();
            rx_in = (k >= inv_lo && k <= inv_hi) ? ~b : b;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stopb,
                              input int inv_bit, input int inv_lo, input int inv_hi);
        align();
        drive_bit(1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            if (i == inv_bit) drive_bit(data[i], inv_lo, inv_hi);
            else              drive_bit(data[i], -1, -1);
        end
        drive_bit(stopb, -1, -1);
    endtask

    int s0, d0, e0, r0;

    initial begin
        rst_n     = 1'b0;
        rx_in     = 1'b1;
        baud_tick = 1'b0;
        step(5);
        check("rst_sample_en",  32'(sample_en),  0);
        check("rst_serial_out", 32'(serial_out), 1);
        check("rst_busy",       32'(busy),       0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_err",  32'(frame_err),  0);
        rst_n = 1'b1;
        idle(4);

        // Frame 0xA5, good stop bit
        s0 = n_samp; d0 = n_done; e0 = n_err; samp_q.delete();
        send_frame(8'hA5, 1'b1, -1, -1, -1);
        idle(4);
        check("a5_samples", 32'(n_samp - s0), 8);
        check("a5_byte",    32'(shreg[15:8]), 32'hA5);
        check("a5_done",    32'(n_done - d0), 1);
        check("a5_err",     32'(n_err - e0),  0);
        check("a5_first_sample_cyc", (samp_q.size() > 0) ? samp_q[0] : -1, frame_c0 + 101 + 4 * VOTE);
        for (int i = 1; i < samp_q.size(); i++)
            check("a5_sample_interval", samp_q[i] - samp_q[i-1], 64);
        check("a5_done_cyc",   last_pulse, frame_c0 + 613 + 4 * VOTE);
        check("a5_busy_drop",  busy_fall,  last_pulse + 1);
        check("a5_busy_idle",  32'(busy),  0);

        // Start glitch: line low for 5 ticks only
        s0 = n_samp; d0 = n_done; e0 = n_err;
        align();
        for (int k = 0; k < 5 * tick_div; k++) begin step(); rx_in = 1'b0; end
        idle(20);
        check("glitch_samples", 32'(n_samp - s0), 0);
        check("glitch_done",    32'(n_done - d0), 0);
        check("glitch_err",     32'(n_err - e0),  VOTE);
        check("glitch_busy_len", last_run, (VOTE != 0) ? 37 : 32);
        check("glitch_busy_idle", 32'(busy), 0);

        // Frame 0x3C with low stop bit, then a held break
        s0 = n_samp; d0 = n_done; e0 = n_err;
        send_frame(8'h3C, 1'b0, -1, -1, -1);
        r0 = busy_rises;
        step(40 * tick_div);
        check("3c_samples", 32'(n_samp - s0), 8);
        check("3c_byte",    32'(shreg[15:8]), 32'h3C);
        check("3c_err",     32'(n_err - e0),  1);
        check("3c_done",    32'(n_done - d0), 0);
        check("break_no_rearm", busy_rises, r0);
        idle(8);

        // Back-to-back 0x00 then 0xFF, no idle gap
        s0 = n_samp; d0 = n_done; e0 = n_err;
        send_frame(8'h00, 1'b1, -1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1, -1);
        idle(4);
        check("b2b_samples", 32'(n_samp - s0), 16);
        check("b2b_bits",    32'(shreg),       32'hFF00);
        check("b2b_done",    32'(n_done - d0), 2);
        check("b2b_err",     32'(n_err - e0),  0);

        // baud_tick held high every clk
        tick_div = 1;
        idle(4);
        s0 = n_samp; d0 = n_done; samp_q.delete();
        send_frame(8'h5A, 1'b1, -1, -1, -1);
        idle(4);
        check("cont_tick_samples", 32'(n_samp - s0), 8);
        check("cont_tick_byte",    32'(shreg[15:8]), 32'h5A);
        check("cont_tick_done",    32'(n_done - d0), 1);
        check("cont_tick_interval", (samp_q.size() > 1) ? samp_q[1] - samp_q[0] : -1, 16);
        tick_div = 4;
        idle(4);

        // Reset in the middle of bit 4 of frame 0xA5
        align();
        drive_bit(1'b0, -1, -1);
        drive_bit(1'b1, -1, -1);
        drive_bit(1'b0, -1, -1);
        drive_bit(1'b1, -1, -1);
        drive_bit(1'b0, -1, -1);
        for (int k = 0; k < 32; k++) begin step(); rx_in = 1'b0; end
        step();
        rst_n = 1'b0;
        rx_in = 1'b1;
        step();
        check("midrst_sample_en",  32'(sample_en),  0);
        check("midrst_serial_out", 32'(serial_out), 1);
        check("midrst_busy",       32'(busy),       0);
        check("midrst_frame_done", 32'(frame_done), 0);
        check("midrst_frame_err",  32'(frame_err),  0);
        step(3);
        rst_n = 1'b1;
        idle(4);
        s0 = n_samp; d0 = n_done; e0 = n_err;
        send_frame(8'h81, 1'b1, -1, -1, -1);
        idle(4);
        check("81_samples", 32'(n_samp - s0), 8);
        check("81_byte",    32'(shreg[15:8]), 32'h81);
        check("81_done",    32'(n_done - d0), 1);
        check("81_err",     32'(n_err - e0),  0);

        // Frame 0x55 with a one-tick inversion exactly at the centre sample of bit 2
        s0 = n_samp; d0 = n_done; samp_q.delete();
        send_frame(8'h55, 1'b1, 2, 32, 35);
        idle(4);
        check("inv_samples", 32'(n_samp - s0), 8);
        check("inv_byte",    32'(shreg[15:8]), (VOTE != 0) ? 32'h55 : 32'h51);
        check("inv_done",    32'(n_done - d0), 1);
        check("inv_first_sample_cyc", (samp_q.size() > 0) ? samp_q[0] : -1, frame_c0 + 101 + 4 * VOTE);

        check("pulse_exclusive", n_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
